// File: rtl/sequencer_fsm_param.sv
// LUT-driven panel sequencer: steps through programmable entries (state, dwell, repeats, flags), with looping and trigger gating.
// Latency: the first entry is visible two cycles after start_i; each entry change adds a one-cycle fetch bubble.
// No backpressure: a LUT write while running is dropped and flagged on lut_wr_err_o; abort_i wins over trigger, dwell and done.
module sequencer_fsm_param #(
    parameter int STATE_W   = 3,
    parameter int ADDR_W    = 4,
    parameter int RPT_W     = 8,
    parameter int LEN_W     = 16,
    parameter int FRM_W     = 8,
    parameter int IDLE_CODE = 1,
    parameter int ENTRY_W   = STATE_W + RPT_W + LEN_W + 3
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic                    lut_wen_i,
    input  logic [ADDR_W-1:0]       lut_waddr_i,
    input  logic [ENTRY_W-1:0]      lut_wdata_i,
    input  logic                    lut_rden_i,
    input  logic [ADDR_W-1:0]       lut_raddr_i,
    output logic [ENTRY_W-1:0]      lut_rdata_o,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    trig_i,
    input  logic [FRM_W-1:0]        frames_i,
    input  logic [ADDR_W-1:0]       loop_addr_i,
    output logic                    busy_o,
    output logic                    sequence_done_o,
    output logic                    lut_wr_err_o,
    output logic                    lut_err_o,
    output logic [STATE_W-1:0]      current_state_o,
    output logic [2**STATE_W-1:0]   state_onehot_o,
    output logic [RPT_W-1:0]        current_repeat_count_o,
    output logic [LEN_W-1:0]        current_data_length_o,
    output logic                    current_eof_o,
    output logic                    current_sof_o,
    output logic [FRM_W-1:0]        frame_cnt_o
);

    localparam int DEPTH    = 2**ADDR_W;
    localparam int ONEHOT_W = 2**STATE_W;
    localparam int OFS_RPT  = STATE_W;
    localparam int OFS_LEN  = STATE_W + RPT_W;
    localparam int OFS_FLG  = STATE_W + RPT_W + LEN_W;
    localparam logic [STATE_W-1:0]  IDLE_S  = STATE_W'(IDLE_CODE);
    localparam logic [ONEHOT_W-1:0] IDLE_OH = ONEHOT_W'(1) << IDLE_CODE;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_TRIG, S_DWELL, S_DONE} state_t;
    state_t r_fsm, w_fsm_nxt;

    logic [ENTRY_W-1:0]  r_mem [DEPTH];
    logic [ENTRY_W-1:0]  r_rdata;
    logic [ADDR_W-1:0]   r_addr;
    logic [FRM_W-1:0]    r_frame_cnt;
    logic [LEN_W-1:0]    r_len_cnt;
    logic [LEN_W-1:0]    r_len;
    logic [RPT_W-1:0]    r_rpt;
    logic [STATE_W-1:0]  r_cur_state;
    logic [ONEHOT_W-1:0] r_onehot;
    logic                r_eof, r_sof, r_busy, r_done, r_wr_err, r_lut_err;

    logic [ENTRY_W-1:0]  w_ent;
    logic [RPT_W-1:0]    w_ent_rpt;
    logic [LEN_W-1:0]    w_ent_len;
    logic                w_dwell_last, w_last_frame;

    assign w_ent        = r_mem[r_addr];
    assign w_ent_rpt    = (w_ent[OFS_RPT +: RPT_W] == '0) ? RPT_W'(1) : w_ent[OFS_RPT +: RPT_W];
    assign w_ent_len    = (w_ent[OFS_LEN +: LEN_W] == '0) ? LEN_W'(1) : w_ent[OFS_LEN +: LEN_W];
    assign w_dwell_last = (r_len_cnt == LEN_W'(1)) && (r_rpt == RPT_W'(1));
    // frames_i is sampled live at each EOF; a count that wraps to 0 never matches a nonzero target
    assign w_last_frame = r_eof && (frames_i != '0) && ((r_frame_cnt + FRM_W'(1)) == frames_i);

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:      if (start_i) w_fsm_nxt = S_FETCH;
            S_FETCH:     w_fsm_nxt = w_ent[OFS_FLG] ? S_WAIT_TRIG : S_DWELL;
            S_WAIT_TRIG: if (trig_i) w_fsm_nxt = S_DWELL;
            S_DWELL:     if (w_dwell_last) w_fsm_nxt = w_last_frame ? S_DONE : S_FETCH;
            S_DONE:      w_fsm_nxt = S_IDLE;
            default:     w_fsm_nxt = S_IDLE;
        endcase
        if (abort_i && (r_fsm != S_IDLE)) w_fsm_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) r_fsm <= S_IDLE;
        else            r_fsm <= w_fsm_nxt;
    end

    // LUT storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (lut_wen_i && (r_fsm == S_IDLE)) r_mem[lut_waddr_i] <= lut_wdata_i;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rdata     <= '0;
            r_addr      <= '0;
            r_frame_cnt <= '0;
            r_len_cnt   <= '0;
            r_len       <= '0;
            r_rpt       <= '0;
            r_cur_state <= IDLE_S;
            r_onehot    <= IDLE_OH;
            r_eof       <= 1'b0;
            r_sof       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_err    <= 1'b0;
            r_lut_err   <= 1'b0;
        end else begin
            r_wr_err <= lut_wen_i && (r_fsm != S_IDLE);
            r_done   <= (w_fsm_nxt == S_DONE);
            r_busy   <= (w_fsm_nxt != S_IDLE);
            if (lut_rden_i) r_rdata <= r_mem[lut_raddr_i];
            if ((r_fsm == S_IDLE) && start_i) begin
                r_addr      <= '0;
                r_frame_cnt <= '0;
                r_lut_err   <= 1'b0;
            end
            if ((r_fsm != S_IDLE) && (w_fsm_nxt == S_IDLE)) begin
                r_cur_state <= IDLE_S;
                r_onehot    <= IDLE_OH;
                r_len_cnt   <= '0;
                r_len       <= '0;
                r_rpt       <= '0;
                r_eof       <= 1'b0;
                r_sof       <= 1'b0;
            end else if (r_fsm == S_FETCH) begin
                r_cur_state <= w_ent[STATE_W-1:0];
                r_onehot    <= ONEHOT_W'(1) << w_ent[STATE_W-1:0];
                r_len_cnt   <= w_ent_len;
                r_len       <= w_ent_len;
                r_rpt       <= w_ent_rpt;
                r_eof       <= w_ent[OFS_FLG+1];
                r_sof       <= w_ent[OFS_FLG+2];
            end else if (r_fsm == S_DWELL) begin
                if (r_len_cnt != LEN_W'(1)) begin
                    r_len_cnt <= r_len_cnt - LEN_W'(1);
                end else if (r_rpt != RPT_W'(1)) begin
                    r_rpt     <= r_rpt - RPT_W'(1);
                    r_len_cnt <= r_len;
                end else if (r_eof) begin
                    if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + FRM_W'(1);
                    if (!w_last_frame) r_addr <= loop_addr_i;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                    if (r_addr == '1) r_lut_err <= 1'b1;
                end
            end
        end
    end

    assign lut_rdata_o            = r_rdata;
    assign busy_o                 = r_busy;
    assign sequence_done_o        = r_done;
    assign lut_wr_err_o           = r_wr_err;
    assign lut_err_o              = r_lut_err;
    assign current_state_o        = r_cur_state;
    assign state_onehot_o         = r_onehot;
    assign current_repeat_count_o = r_rpt;
    assign current_data_length_o  = r_len;
    assign current_eof_o          = r_eof;
    assign current_sof_o          = r_sof;
    assign frame_cnt_o            = r_frame_cnt;

endmodule

// File: tb/tb_sequencer_fsm_param.sv
// Directed bench for sequencer_fsm_param: default-size instance plus an ADDR_W=2 instance for the wrap case.
module tb_sequencer_fsm_param;
    localparam int STATE_W = 3;
    localparam int RPT_W   = 8;
    localparam int LEN_W   = 16;
    localparam int FRM_W   = 8;
    localparam int ENTRY_W = STATE_W + RPT_W + LEN_W + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n_i;
    logic               lut_wen_i, lut_rden_i, start_i, abort_i, trig_i;
    logic [3:0]         lut_waddr_i, lut_raddr_i, loop_addr_i;
    logic [ENTRY_W-1:0] lut_wdata_i, lut_rdata_o;
    logic [FRM_W-1:0]   frames_i, frame_cnt_o;
    logic               busy_o, sequence_done_o, lut_wr_err_o, lut_err_o, current_eof_o, current_sof_o;
    logic [STATE_W-1:0] current_state_o;
    logic [7:0]         state_onehot_o;
    logic [RPT_W-1:0]   current_repeat_count_o;
    logic [LEN_W-1:0]   current_data_length_o;

    logic               wen2, start2;
    logic [1:0]         waddr2;
    logic [ENTRY_W-1:0] rdata2;
    logic               busy2, done2, wr_err2, lut_err2, eof2, sof2;
    logic [STATE_W-1:0] state2;
    logic [7:0]         onehot2;
    logic [RPT_W-1:0]   rpt2;
    logic [LEN_W-1:0]   len2;
    logic [FRM_W-1:0]   frame2;

    int checks = 0;
    int errors = 0;

    sequencer_fsm_param dut (
        .clk(clk), .reset_n_i(reset_n_i),
        .lut_wen_i(lut_wen_i), .lut_waddr_i(lut_waddr_i), .lut_wdata_i(lut_wdata_i),
        .lut_rden_i(lut_rden_i), .lut_raddr_i(lut_raddr_i), .lut_rdata_o(lut_rdata_o),
        .start_i(start_i), .abort_i(abort_i), .trig_i(trig_i),
        .frames_i(frames_i), .loop_addr_i(loop_addr_i),
        .busy_o(busy_o), .sequence_done_o(sequence_done_o),
        .lut_wr_err_o(lut_wr_err_o), .lut_err_o(lut_err_o),
        .current_state_o(current_state_o), .state_onehot_o(state_onehot_o),
        .current_repeat_count_o(current_repeat_count_o),
        .current_data_length_o(current_data_length_o),
        .current_eof_o(current_eof_o), .current_sof_o(current_sof_o),
        .frame_cnt_o(frame_cnt_o)
    );

    sequencer_fsm_param #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset_n_i(reset_n_i),
        .lut_wen_i(wen2), .lut_waddr_i(waddr2), .lut_wdata_i(lut_wdata_i),
        .lut_rden_i(1'b0), .lut_raddr_i(2'd0), .lut_rdata_o(rdata2),
        .start_i(start2), .abort_i(abort_i), .trig_i(trig_i),
        .frames_i(8'd0), .loop_addr_i(2'd0),
        .busy_o(busy2), .sequence_done_o(done2),
        .lut_wr_err_o(wr_err2), .lut_err_o(lut_err2),
        .current_state_o(state2), .state_onehot_o(onehot2),
        .current_repeat_count_o(rpt2), .current_data_length_o(len2),
        .current_eof_o(eof2), .current_sof_o(sof2),
        .frame_cnt_o(frame2)
    );

    function automatic logic [ENTRY_W-1:0] ent(input logic sof, input logic eof, input logic wt,
                                               input int len, input int rpt, input int st);
        ent = {sof, eof, wt, LEN_W'(len), RPT_W'(rpt), STATE_W'(st)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [ENTRY_W-1:0] d);
        lut_wen_i = 1'b1; lut_waddr_i = a; lut_wdata_i = d;
        step();
        lut_wen_i = 1'b0;
    endtask

    task automatic wr2(input logic [1:0] a, input logic [ENTRY_W-1:0] d);
        wen2 = 1'b1; waddr2 = a; lut_wdata_i = d;
        step();
        wen2 = 1'b0;
    endtask

    // Leaves the bench just after the second edge: first entry visible
    task automatic go();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        #23;
        checks++;
        if (current_state_o !== 3'd1 || state_onehot_o !== 8'h02 || busy_o !== 1'b0 ||
            lut_rdata_o !== '0 || frame_cnt_o !== '0 || sequence_done_o !== 1'b0 ||
            lut_err_o !== 1'b0 || lut_wr_err_o !== 1'b0 || current_repeat_count_o !== '0 ||
            current_data_length_o !== '0 || current_eof_o !== 1'b0 || current_sof_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got st=%0d oh=%h busy=%b rd=%h fc=%0d want st=1 oh=02 others 0",
                     current_state_o, state_onehot_o, busy_o, lut_rdata_o, frame_cnt_o);
        end
        @(negedge clk);
        reset_n_i = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int exp_st;
        wr(4'd0, ent(1, 0, 0, 5, 2, 2));
        wr(4'd1, ent(0, 1, 0, 3, 1, 1));
        wr(4'd3, ent(0, 0, 0, 7, 7, 7));
        frames_i = 8'd1; loop_addr_i = 4'd0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        checks++;
        if (current_state_o !== 3'd1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_fetch got st=%0d busy=%b want st=1 busy=1", current_state_o, busy_o);
        end
        step();
        for (int i = 0; i < 16; i++) begin
            exp_st = (i < 11) ? 2 : 1;
            checks++;
            if (current_state_o !== STATE_W'(exp_st) || busy_o !== (i < 15) ||
                sequence_done_o !== (i == 14)) begin
                errors++;
                $display("FAIL basic_seq cyc %0d got st=%0d busy=%b done=%b want st=%0d busy=%b done=%b",
                         i, current_state_o, busy_o, sequence_done_o, exp_st, i < 15, i == 14);
            end
            if (i == 0) begin
                checks++;
                if (current_repeat_count_o !== 8'd2 || current_data_length_o !== 16'd5 ||
                    current_sof_o !== 1'b1 || state_onehot_o !== 8'h04) begin
                    errors++;
                    $display("FAIL basic_entry0 got rpt=%0d len=%0d sof=%b oh=%h want 2 5 1 04",
                             current_repeat_count_o, current_data_length_o, current_sof_o, state_onehot_o);
                end
            end
            if (i == 5) begin
                checks++;
                if (current_repeat_count_o !== 8'd1) begin
                    errors++;
                    $display("FAIL basic_rpt_dec got %0d want 1", current_repeat_count_o);
                end
            end
            if (i == 15) begin
                checks++;
                if (frame_cnt_o !== 8'd1 || state_onehot_o !== 8'h02 || current_data_length_o !== '0) begin
                    errors++;
                    $display("FAIL basic_idle got fc=%0d oh=%h len=%0d want 1 02 0",
                             frame_cnt_o, state_onehot_o, current_data_length_o);
                end
            end
            step();
        end
    endtask

    task automatic test_wr_err();
        int budget;
        go();
        step();
        wr(4'd3, ent(0, 0, 0, 9, 9, 4));
        checks++;
        if (lut_wr_err_o !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_pulse got %b want 1", lut_wr_err_o);
        end
        step();
        checks++;
        if (lut_wr_err_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_clear got %b want 0", lut_wr_err_o);
        end
        lut_rden_i = 1'b1; lut_raddr_i = 4'd3;
        step();
        lut_rden_i = 1'b0;
        checks++;
        if (lut_rdata_o !== ent(0, 0, 0, 7, 7, 7)) begin
            errors++;
            $display("FAIL wr_err_old_data got %h want %h", lut_rdata_o, ent(0, 0, 0, 7, 7, 7));
        end
        budget = 0;
        while (busy_o === 1'b1 && budget < 50) begin
            step();
            budget++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_wait_idle busy=%b after %0d cycles want 0", busy_o, budget);
        end
        lut_wen_i = 1'b1; lut_waddr_i = 4'd3; lut_wdata_i = ent(0, 0, 0, 9, 9, 4);
        lut_rden_i = 1'b1; lut_raddr_i = 4'd3;
        step();
        lut_wen_i = 1'b0;
        checks++;
        if (lut_rdata_o !== ent(0, 0, 0, 7, 7, 7) || lut_wr_err_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_same_edge got %h err=%b want %h err=0", lut_rdata_o, lut_wr_err_o,
                     ent(0, 0, 0, 7, 7, 7));
        end
        step();
        lut_rden_i = 1'b0; lut_raddr_i = 4'd0;
        checks++;
        if (lut_rdata_o !== ent(0, 0, 0, 9, 9, 4)) begin
            errors++;
            $display("FAIL rd_new_data got %h want %h", lut_rdata_o, ent(0, 0, 0, 9, 9, 4));
        end
        step();
        checks++;
        if (lut_rdata_o !== ent(0, 0, 0, 9, 9, 4)) begin
            errors++;
            $display("FAIL rd_hold got %h want %h", lut_rdata_o, ent(0, 0, 0, 9, 9, 4));
        end
    endtask

    task automatic test_trig();
        wr(4'd0, ent(0, 1, 1, 4, 1, 5));
        frames_i = 8'd1;
        go();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (current_state_o !== 3'd5 || busy_o !== 1'b1 || sequence_done_o !== 1'b0) begin
                errors++;
                $display("FAIL trig_wait cyc %0d got st=%0d busy=%b done=%b want 5 1 0",
                         i, current_state_o, busy_o, sequence_done_o);
            end
            step();
        end
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (current_state_o !== 3'd5 || sequence_done_o !== 1'b0) begin
                errors++;
                $display("FAIL trig_dwell cyc %0d got st=%0d done=%b want 5 0", j, current_state_o, sequence_done_o);
            end
            step();
        end
        checks++;
        if (sequence_done_o !== 1'b1 || frame_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL trig_done got done=%b fc=%0d want 1 1", sequence_done_o, frame_cnt_o);
        end
        step();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL trig_idle got busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_loop();
        int exp_lp [15] = '{3, 3, 3, 4, 4, 6, 6, 4, 4, 6, 6, 4, 4, 6, 6};
        int done_cnt = 0;
        wr(4'd0, ent(0, 0, 0, 2, 1, 3));
        wr(4'd1, ent(0, 0, 0, 1, 1, 4));
        wr(4'd2, ent(0, 1, 0, 1, 1, 6));
        frames_i = 8'd3; loop_addr_i = 4'd1;
        go();
        for (int i = 0; i < 25; i++) begin
            if (i < 15) begin
                checks++;
                if (current_state_o !== STATE_W'(exp_lp[i])) begin
                    errors++;
                    $display("FAIL loop_seq cyc %0d got st=%0d want %0d", i, current_state_o, exp_lp[i]);
                end
            end
            if (sequence_done_o === 1'b1) done_cnt++;
            step();
        end
        checks++;
        if (done_cnt != 1 || frame_cnt_o !== 8'd3 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL loop_end got done_pulses=%0d fc=%0d busy=%b want 1 3 0", done_cnt, frame_cnt_o, busy_o);
        end
        loop_addr_i = 4'd0;
    endtask

    task automatic test_abort();
        int done_seen = 0;
        wr(4'd0, ent(0, 0, 0, 5, 2, 2));
        wr(4'd1, ent(0, 1, 0, 3, 1, 1));
        frames_i = 8'd1;
        go();
        step();
        step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || current_state_o !== 3'd1 || state_onehot_o !== 8'h02 ||
            sequence_done_o !== 1'b0 || current_repeat_count_o !== '0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b st=%0d oh=%h done=%b rpt=%0d want 0 1 02 0 0",
                     busy_o, current_state_o, state_onehot_o, sequence_done_o, current_repeat_count_o);
        end
        for (int i = 0; i < 15; i++) begin
            if (sequence_done_o === 1'b1) done_seen++;
            step();
        end
        checks++;
        if (done_seen != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done got pulses=%0d busy=%b want 0 0", done_seen, busy_o);
        end
        go();
        step();
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || current_state_o !== 3'd1 || state_onehot_o !== 8'h02 ||
            current_data_length_o !== '0 || sequence_done_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got busy=%b st=%0d oh=%h len=%0d done=%b want 0 1 02 0 0",
                     busy_o, current_state_o, state_onehot_o, current_data_length_o, sequence_done_o);
        end
        step();
        reset_n_i = 1'b1;
        lut_rden_i = 1'b1; lut_raddr_i = 4'd0;
        step();
        lut_rden_i = 1'b0;
        checks++;
        if (lut_rdata_o !== ent(0, 0, 0, 5, 2, 2) || frame_cnt_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_keeps_lut got rd=%h fc=%0d busy=%b want %h 0 0",
                     lut_rdata_o, frame_cnt_o, busy_o, ent(0, 0, 0, 5, 2, 2));
        end
    endtask

    task automatic test_wrap();
        int exp_w [9] = '{4, 4, 5, 5, 6, 6, 7, 7, 4};
        for (int a = 0; a < 4; a++) wr2(2'(a), ent(0, 0, 0, 1, 1, a + 4));
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        step();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (state2 !== STATE_W'(exp_w[i]) || lut_err2 !== (i >= 7) || busy2 !== 1'b1) begin
                errors++;
                $display("FAIL wrap_seq cyc %0d got st=%0d err=%b busy=%b want %0d %b 1",
                         i, state2, lut_err2, busy2, exp_w[i], i >= 7);
            end
            step();
        end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        checks++;
        if (busy2 !== 1'b0 || lut_err2 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_sticky got busy=%b err=%b want 0 1", busy2, lut_err2);
        end
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        checks++;
        if (lut_err2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_restart_clear got err=%b busy=%b want 0 1", lut_err2, busy2);
        end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        step();
    endtask

    initial begin
        reset_n_i = 1'b0;
        lut_wen_i = 1'b0; lut_waddr_i = '0; lut_wdata_i = '0;
        lut_rden_i = 1'b0; lut_raddr_i = '0;
        start_i = 1'b0; abort_i = 1'b0; trig_i = 1'b0;
        frames_i = '0; loop_addr_i = '0;
        wen2 = 1'b0; waddr2 = '0; start2 = 1'b0;
        test_reset();
        test_basic();
        test_wr_err();
        test_trig();
        test_loop();
        test_abort();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
